// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared constants and types for the divider result path
//
// Purpose: op-select encoding carried in the request tag and the default
//          per-lane result type used by the divider writeback stages.
// Ports:   none (package).
package div_pkg;

    // Tag bit that chooses which divider output is written back.
    localparam int DIV_SEL_BIT = 0;

    localparam logic DIV_SEL_QUO = 1'b0;
    localparam logic DIV_SEL_REM = 1'b1;

    // One lane of quotient/remainder at the default 32-bit width.
    typedef logic [31:0] div_lane_t;

endpackage

// File: rtl/div_result_store.sv
// rtl/div_result_store.sv - DEPTH-entry register array for the result queue
//
// Purpose: storage for queued divider results; one synchronous write port,
//          one asynchronous read port. Contents are not reset.
// Ports:
//   clk      in   clock
//   we       in   write enable
//   wr_ptr   in   write entry index
//   wr_data  in   entry to write
//   rd_ptr   in   read entry index
//   rd_data  out  entry at rd_ptr (combinational)
module div_result_store #(
    parameter int DEPTH = 4,
    parameter int DW    = 40,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [PW-1:0] wr_ptr,
    input  logic [DW-1:0] wr_data,
    input  logic [PW-1:0] rd_ptr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/div_result_queue.sv
// rtl/div_result_queue.sv - result select and FIFO behind the serial divider
//
// Purpose: captures each completed divide, keeps quotient or remainder as
//          chosen by tag bit 0, and buffers it so writeback stalls never
//          hold the divider's output handshake. Strict FIFO order, no
//          fall-through: a push is visible at the output the next cycle.
// Optional: VX_DIV_RESULT_PERF_EN adds perf_stall_cycles, a wrapping count of
//          cycles where the divider offered a result while the queue was full.
// Ports:
//   clk               in   clock
//   reset             in   asynchronous active-high reset
//   valid_in          in   divider result valid
//   ready_in          out  queue can accept a result (registered, !full)
//   quotient_in       in   per-lane quotient   (LANES*WIDTH)
//   remainder_in      in   per-lane remainder  (LANES*WIDTH)
//   tag_in            in   request tag, bit0 = 1 selects remainder
//   valid_out         out  head entry valid (registered, !empty)
//   ready_out         in   writeback accepts
//   result_out        out  selected per-lane result of head entry
//   tag_out           out  tag of head entry
//   perf_stall_cycles out  back-pressure cycle count (perf build only)
module div_result_queue
    import div_pkg::*;
#(
    parameter int LANES = 1,
    parameter int WIDTH = 32,
    parameter int TAGW  = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   valid_in,
    output logic                   ready_in,
    input  logic [LANES*WIDTH-1:0] quotient_in,
    input  logic [LANES*WIDTH-1:0] remainder_in,
    input  logic [TAGW-1:0]        tag_in,
    output logic                   valid_out,
    input  logic                   ready_out,
    output logic [LANES*WIDTH-1:0] result_out,
    output logic [TAGW-1:0]        tag_out
`ifdef VX_DIV_RESULT_PERF_EN
    ,
    output logic [31:0]            perf_stall_cycles
`endif
);

    localparam int RW = LANES * WIDTH;
    localparam int DW = RW + TAGW;
    localparam int PW = $clog2(DEPTH);

    localparam logic [PW:0]   CNT_ONE  = 1;
    localparam logic [PW:0]   CNT_FULL = DEPTH;
    localparam logic [PW-1:0] PTR_ONE  = 1;

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    logic [PW:0]   count_nxt;
    logic          full_q;
    logic          empty_q;
    logic          push;
    logic          pop;
    logic [RW-1:0] sel_result;
    logic [DW-1:0] rd_data;

    assign ready_in  = !full_q;
    assign valid_out = !empty_q;
    assign push      = valid_in && !full_q;
    assign pop       = !empty_q && ready_out;

    // The op-select applies to every lane of the request, so the choice is
    // made once on the whole vector before it is written.
    assign sel_result = (tag_in[DIV_SEL_BIT] == DIV_SEL_QUO) ? quotient_in : remainder_in;

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + CNT_ONE;
        end else if (pop && !push) begin
            count_nxt = count - CNT_ONE;
        end
    end

    // full/empty are flopped from the next count so neither handshake output
    // has a combinational path from any input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count   <= count_nxt;
            full_q  <= (count_nxt == CNT_FULL);
            empty_q <= (count_nxt == '0);
        end
    end

    div_result_store #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .PW    (PW)
    ) u_store (
        .clk     (clk),
        .we      (push),
        .wr_ptr  (wr_ptr),
        .wr_data ({tag_in, sel_result}),
        .rd_ptr  (rd_ptr),
        .rd_data (rd_data)
    );

    assign result_out = rd_data[RW-1:0];
    assign tag_out    = rd_data[DW-1:RW];

`ifdef VX_DIV_RESULT_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_cycles <= '0;
        end else if (valid_in && full_q) begin
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_div_result_queue.sv
// tb/tb_div_result_queue.sv - directed self-checking bench for div_result_queue
module tb_div_result_queue;
    import div_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_in = 1'b0;
    logic        ready_in;
    logic [63:0] quotient_in = '0;
    logic [63:0] remainder_in = '0;
    logic [7:0]  tag_in = '0;
    logic        valid_out;
    logic        ready_out = 1'b0;
    logic [63:0] result_out;
    logic [7:0]  tag_out;
`ifdef VX_DIV_RESULT_PERF_EN
    logic [31:0] perf_stall_cycles;
`endif

    int total = 0;
    int bad = 0;

    div_lane_t q1, q0, r1, r0;
    logic [63:0] quo_vec, rem_vec;
    logic [7:0]  exp_tag;

    always #5 clk = ~clk;

    div_result_queue #(
        .LANES (2),
        .WIDTH (32),
        .TAGW  (8),
        .DEPTH (4)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .valid_in          (valid_in),
        .ready_in          (ready_in),
        .quotient_in       (quotient_in),
        .remainder_in      (remainder_in),
        .tag_in            (tag_in),
        .valid_out         (valid_out),
        .ready_out         (ready_out),
        .result_out        (result_out),
        .tag_out           (tag_out)
`ifdef VX_DIV_RESULT_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    initial begin
        q1 = 32'd7; q0 = 32'd3; r1 = 32'd1; r0 = 32'd2;
        quo_vec = {q1, q0};
        rem_vec = {r1, r0};
        quotient_in  = quo_vec;
        remainder_in = rem_vec;

        // Reset state
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_valid_out", 64'(valid_out), 64'd0);
        check("rst_ready_in", 64'(ready_in), 64'd1);
`ifdef VX_DIV_RESULT_PERF_EN
        check("rst_perf", 64'(perf_stall_cycles), 64'd0);
`endif

        // Quotient select, one-cycle latency, then pop
        valid_in = 1'b1; tag_in = 8'h10;
        @(negedge clk);
        valid_in = 1'b0;
        check("q_valid", 64'(valid_out), 64'd1);
        check("q_result", result_out, {32'd7, 32'd3});
        check("q_tag", 64'(tag_out), 64'h10);
        ready_out = 1'b1;
        @(negedge clk);
        ready_out = 1'b0;
        check("q_pop_empty", 64'(valid_out), 64'd0);

        // Remainder select
        valid_in = 1'b1; tag_in = 8'h11;
        @(negedge clk);
        valid_in = 1'b0;
        check("r_result", result_out, {32'd1, 32'd2});
        check("r_tag", 64'(tag_out), 64'h11);
        ready_out = 1'b1;
        @(negedge clk);
        ready_out = 1'b0;
        check("r_pop_empty", 64'(valid_out), 64'd0);

        // Fill to full, held 5th request ignored, drain in order
        for (int i = 1; i <= 4; i++) begin
            check("fill_ready", 64'(ready_in), 64'd1);
            valid_in = 1'b1; tag_in = 8'(2 * i);
            @(negedge clk);
        end
        check("full_ready_in", 64'(ready_in), 64'd0);
        tag_in = 8'h0A;
        repeat (2) @(negedge clk);
        check("full_held_ready", 64'(ready_in), 64'd0);
        valid_in = 1'b0;
        ready_out = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("drain_valid", 64'(valid_out), 64'd1);
            check("drain_tag", 64'(tag_out), 64'(2 * i));
            if (i == 1) check("drain_ready_same", 64'(ready_in), 64'd0);
            if (i == 2) check("drain_ready_next", 64'(ready_in), 64'd1);
            @(negedge clk);
        end
        check("drain_empty", 64'(valid_out), 64'd0);
        ready_out = 1'b0;

        // Steady state at count 2 with simultaneous push/pop, pointer wrap
        for (int i = 0; i < 2; i++) begin
            valid_in = 1'b1; tag_in = 8'(8'h30 + i);
            @(negedge clk);
        end
        ready_out = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tag_in = 8'(8'h32 + i);
            exp_tag = 8'(8'h30 + i);
            check("ss_ready_in", 64'(ready_in), 64'd1);
            check("ss_tag", 64'(tag_out), 64'(exp_tag));
            check("ss_result", result_out, exp_tag[0] ? rem_vec : quo_vec);
            @(negedge clk);
        end
        valid_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("ss_tail_valid", 64'(valid_out), 64'd1);
            check("ss_tail_tag", 64'(tag_out), 64'(8'h3A + i));
            @(negedge clk);
        end
        check("ss_drained", 64'(valid_out), 64'd0);
        ready_out = 1'b0;

        // Asynchronous reset mid-operation
        for (int i = 0; i < 3; i++) begin
            valid_in = 1'b1; tag_in = 8'(8'h40 + i);
            @(negedge clk);
        end
        valid_in = 1'b0;
        check("pre_rst_valid", 64'(valid_out), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_valid", 64'(valid_out), 64'd0);
        check("async_rst_ready", 64'(ready_in), 64'd1);
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check("post_rst_empty", 64'(valid_out), 64'd0);
        valid_in = 1'b1; tag_in = 8'h20;
        @(negedge clk);
        valid_in = 1'b0;
        check("post_rst_tag", 64'(tag_out), 64'h20);
        ready_out = 1'b1;
        @(negedge clk);
        ready_out = 1'b0;
        check("post_rst_single", 64'(valid_out), 64'd0);

        // Back-pressure: fill, hold valid_in for 5 cycles while full
        for (int i = 0; i < 4; i++) begin
            valid_in = 1'b1; tag_in = 8'(8'h50 + i);
            @(negedge clk);
        end
        repeat (5) @(negedge clk);
        valid_in = 1'b0;
        check("bp_full", 64'(ready_in), 64'd0);
        check("bp_head", 64'(tag_out), 64'h50);
`ifdef VX_DIV_RESULT_PERF_EN
        check("perf_count", 64'(perf_stall_cycles), 64'd5);
`endif
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("bp_rst_valid", 64'(valid_out), 64'd0);
`ifdef VX_DIV_RESULT_PERF_EN
        check("perf_rst", 64'(perf_stall_cycles), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
